// File: rtl/lieat_lzc_arb_ctrl.sv
// Two-port round-robin front end sharing one 32-bit leading-zero counter.
// Stage A holds the granted operand, stage B holds the finished count/normalised result.
module lieat_lzc #(
    parameter int W  = 32,
    parameter int CW = 6
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] cnt_o
);
    // Ascending scan: the highest set bit is written last and wins.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) cnt_o = CW'(W - 1 - i);
        end
    end
endmodule

module lieat_lzc_arb_ctrl #(
    parameter int XLEN = 32,
    parameter int CNTW = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [1:0]      req0_op_i,
    input  logic [XLEN-1:0] req0_data_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [1:0]      req1_op_i,
    input  logic [XLEN-1:0] req1_data_i,
    output logic            resp0_valid_o,
    input  logic            resp0_ready_i,
    output logic            resp1_valid_o,
    input  logic            resp1_ready_i,
    output logic [CNTW-1:0] resp_cnt_o,
    output logic [XLEN-1:0] resp_data_o
);
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_NORM = 2'b10;

    typedef struct packed {
        logic            owner;
        logic [1:0]      op;
        logic [XLEN-1:0] data;
    } a_ent_t;

    typedef struct packed {
        logic            owner;
        logic [CNTW-1:0] cnt;
        logic [XLEN-1:0] data;
    } b_ent_t;

    logic   a_valid_q, a_valid_d;
    a_ent_t a_q, a_d;
    logic   b_valid_q, b_valid_d;
    b_ent_t b_q, b_d;
    logic   last_grant_q, last_grant_d;

    logic v0, v1, gnt0, gnt1;
    logic b_can_load, a_can_load;
    logic acc0, acc1, b_out_fire;

    logic [XLEN-1:0] rev_data, lzc_in;
    logic [CNTW-1:0] lzc_cnt;
    b_ent_t          b_new;

    // Port 0 is masked out of arbitration while flushing so port 1 is not starved that cycle.
    always_comb begin
        v0         = req0_valid_i & ~flush_i;
        v1         = req1_valid_i;
        gnt0       = v0 & (~v1 | last_grant_q);
        gnt1       = v1 & (~v0 | ~last_grant_q);
        b_can_load = ~b_valid_q | (b_q.owner ? resp1_ready_i : resp0_ready_i);
        a_can_load = ~a_valid_q | b_can_load;
        acc0       = req0_valid_i & gnt0 & a_can_load;
        acc1       = req1_valid_i & gnt1 & a_can_load;
        b_out_fire = b_valid_q & (b_q.owner ? resp1_ready_i : resp0_ready_i);
    end

    assign req0_ready_o = gnt0 & a_can_load;
    assign req1_ready_o = gnt1 & a_can_load;

    always_comb begin
        for (int i = 0; i < XLEN; i++) rev_data[i] = a_q.data[XLEN-1-i];
        lzc_in = (a_q.op == OP_CTZ) ? rev_data : a_q.data;
    end

    lieat_lzc #(.W(XLEN), .CW(CNTW)) u_lzc (
        .data_i (lzc_in),
        .cnt_o  (lzc_cnt)
    );

    // A zero operand gives a count of XLEN, which shifts NORM data out to zero.
    always_comb begin
        b_new.owner = a_q.owner;
        b_new.cnt   = lzc_cnt;
        b_new.data  = (a_q.op == OP_NORM) ? (a_q.data << lzc_cnt) : '0;
    end

    always_comb begin
        a_valid_d    = a_valid_q;
        a_d          = a_q;
        b_valid_d    = b_valid_q;
        b_d          = b_q;
        last_grant_d = last_grant_q;

        if (acc0 | acc1) begin
            a_valid_d    = 1'b1;
            a_d.owner    = acc1;
            a_d.op       = acc1 ? req1_op_i : req0_op_i;
            a_d.data     = acc1 ? req1_data_i : req0_data_i;
            last_grant_d = acc1;
        end else if (a_valid_q & b_can_load) begin
            a_valid_d = 1'b0;
        end

        if (a_valid_q & b_can_load) begin
            b_valid_d = 1'b1;
            b_d       = b_new;
        end else if (b_out_fire) begin
            b_valid_d = 1'b0;
        end

        if (flush_i) begin
            if (!a_d.owner) a_valid_d = 1'b0;
            if (!b_d.owner) b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_valid_q    <= 1'b0;
            a_q          <= '0;
            b_valid_q    <= 1'b0;
            b_q          <= '0;
            last_grant_q <= 1'b1;
        end else begin
            a_valid_q    <= a_valid_d;
            a_q          <= a_d;
            b_valid_q    <= b_valid_d;
            b_q          <= b_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp0_valid_o = b_valid_q & ~b_q.owner;
    assign resp1_valid_o = b_valid_q &  b_q.owner;
    assign resp_cnt_o    = b_q.cnt;
    assign resp_data_o   = b_q.data;
endmodule

// File: tb/tb_lieat_lzc_arb_ctrl.sv
// Randomised bench for lieat_lzc_arb_ctrl: an in-flight queue model predicts readies,
// response valids and results; a negedge monitor compares them against the DUT.
module tb_lieat_lzc_arb_ctrl;
    logic        clock, reset, flush;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [5:0]  resp_cnt;
    logic [31:0] resp_data;

    lieat_lzc_arb_ctrl dut (
        .clock(clock), .reset(reset), .flush_i(flush),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op), .req0_data_i(req0_data),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op), .req1_data_i(req1_data),
        .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready),
        .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready),
        .resp_cnt_o(resp_cnt), .resp_data_o(resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          owner;
        bit          in_b;
        logic [5:0]  cnt;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    bit   lg;
    bit   post_rst;
    int   n_cmp, n_err;

    function automatic logic [5:0] f_clz(input logic [31:0] d);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) break;
            n++;
        end
        return 6'(n);
    endfunction

    function automatic logic [5:0] f_ctz(input logic [31:0] d);
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) break;
            n++;
        end
        return 6'(n);
    endfunction

    function automatic ent_t mk(input bit owner, input logic [1:0] op, input logic [31:0] d);
        ent_t e;
        e.owner = owner;
        e.in_b  = 1'b0;
        e.cnt   = (op == 2'b01) ? f_ctz(d) : f_clz(d);
        e.data  = (op == 2'b10 && d != 0) ? (d << f_clz(d)) : 32'h0;
        return e;
    endfunction

    function automatic bit head_ready();
        if (q.size() == 0 || !q[0].in_b) return 1'b0;
        return q[0].owner ? resp1_ready : resp0_ready;
    endfunction

    function automatic void predict(output bit r0, output bit r1, output bit bcl);
        bit hb, ha, acl, v0, v1;
        hb  = (q.size() != 0) && q[0].in_b;
        ha  = (q.size() != 0) && !q[q.size()-1].in_b;
        bcl = !hb || head_ready();
        acl = !ha || bcl;
        v0  = req0_valid && !flush;
        v1  = req1_valid;
        r0  = v0 && (!v1 || lg) && acl;
        r1  = v1 && (!v0 || !lg) && acl;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Reference model update at each rising edge.
    initial begin
        bit r0, r1, bcl;
        ent_t nq[$];
        ent_t e;
        lg = 1'b1;
        forever begin
            @(posedge clock);
            if (reset) begin
                q.delete();
                lg       = 1'b1;
                post_rst = 1'b1;
            end else begin
                predict(r0, r1, bcl);
                if (head_ready()) void'(q.pop_front());
                if (q.size() != 0 && !q[q.size()-1].in_b && bcl) begin
                    e = q[q.size()-1];
                    e.in_b = 1'b1;
                    q[q.size()-1] = e;
                end
                if (flush) begin
                    nq.delete();
                    foreach (q[i]) if (q[i].owner) nq.push_back(q[i]);
                    q = nq;
                end
                if (req0_valid && r0) begin
                    q.push_back(mk(1'b0, req0_op, req0_data));
                    lg = 1'b0;
                end else if (req1_valid && r1) begin
                    q.push_back(mk(1'b1, req1_op, req1_data));
                    lg = 1'b1;
                end
            end
        end
    end

    // Monitor: compare readies, response valids and response payload each cycle.
    initial begin
        bit r0, r1, bcl, ev0, ev1;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (post_rst) begin
                    chk("rst_cnt", 32'(resp_cnt), 32'h0);
                    chk("rst_data", resp_data, 32'h0);
                    post_rst = 1'b0;
                end
                predict(r0, r1, bcl);
                ev0 = (q.size() != 0) && q[0].in_b && !q[0].owner;
                ev1 = (q.size() != 0) && q[0].in_b &&  q[0].owner;
                chk("req0_ready", 32'(req0_ready), 32'(r0));
                chk("req1_ready", 32'(req1_ready), 32'(r1));
                chk("resp0_valid", 32'(resp0_valid), 32'(ev0));
                chk("resp1_valid", 32'(resp1_valid), 32'(ev1));
                if (ev0 || ev1) begin
                    chk("resp_cnt", 32'(resp_cnt), 32'(q[0].cnt));
                    chk("resp_data", resp_data, q[0].data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 0; req1_valid = 0; flush = 0;
        repeat (n) step();
    endtask

    task automatic one(input bit p, input logic [1:0] op, input logic [31:0] d);
        if (p) begin req1_valid = 1; req1_op = op; req1_data = d; end
        else   begin req0_valid = 1; req0_op = op; req0_data = d; end
        step();
        idle(3);
    endtask

    function automatic logic [31:0] rdata();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'h1 << $urandom_range(0, 31);
            2: return r >> $urandom_range(0, 31);
            default: return r;
        endcase
    endfunction

    initial begin
        n_cmp = 0; n_err = 0; post_rst = 0;
        reset = 1; flush = 0;
        req0_valid = 0; req0_op = 0; req0_data = 0;
        req1_valid = 0; req1_op = 0; req1_data = 0;
        resp0_ready = 1; resp1_ready = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        step();

        one(0, 2'b00, 32'h0001_0000);
        one(1, 2'b10, 32'h0000_00F0);
        one(1, 2'b10, 32'h0000_0000);
        one(0, 2'b01, 32'h8000_0000);
        one(0, 2'b01, 32'h0000_0000);
        one(1, 2'b11, 32'h0000_0100);
        one(0, 2'b00, 32'h0000_0000);

        // Both ports streaming, responses always ready.
        repeat (12) begin
            req0_valid = 1; req0_op = 2'($urandom); req0_data = rdata();
            req1_valid = 1; req1_op = 2'($urandom); req1_data = rdata();
            step();
        end
        idle(3);

        // Port-0 response stalls while port 1 streams.
        req0_valid = 1; req0_op = 2'b00; req0_data = 32'h0000_0F00;
        step();
        req0_valid = 0; resp0_ready = 0;
        repeat (4) begin
            req1_valid = 1; req1_op = 2'b10; req1_data = rdata();
            step();
        end
        req1_valid = 0; resp0_ready = 1;
        idle(5);

        // Flush with port-0 entries in A and B and port 1 waiting.
        resp0_ready = 0;
        repeat (3) begin
            req0_valid = 1; req0_op = 2'b01; req0_data = rdata();
            step();
        end
        flush = 1; req1_valid = 1; req1_op = 2'b00; req1_data = 32'h0000_1234;
        step();
        flush = 0; req0_valid = 0;
        step();
        req1_valid = 0; resp0_ready = 1;
        idle(4);

        // Random traffic with backpressure and occasional flush.
        repeat (3000) begin
            req0_valid  = ($urandom_range(0, 9) < 7);
            req0_op     = 2'($urandom);
            req0_data   = rdata();
            req1_valid  = ($urandom_range(0, 9) < 7);
            req1_op     = 2'($urandom);
            req1_data   = rdata();
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 0; resp0_ready = 1; resp1_ready = 1;
        idle(4);

        // Reset with both stages full, then a tie.
        resp0_ready = 0; resp1_ready = 0;
        repeat (3) begin
            req0_valid = 1; req0_op = 2'b10; req0_data = rdata();
            req1_valid = 1; req1_op = 2'b10; req1_data = rdata();
            step();
        end
        reset = 1;
        step();
        reset = 0; resp0_ready = 1; resp1_ready = 1;
        repeat (6) begin
            req0_valid = 1; req0_op = 2'b00; req0_data = rdata();
            req1_valid = 1; req1_op = 2'b01; req1_data = rdata();
            step();
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lieat_lzc_arb_ctrl.md
Name: lieat_lzc_arb_ctrl

Overview:
- Shares one 32-bit leading-zero-count datapath between two requesters.
  - Port 0: ALU bit-manip path (CLZ/CTZ).
  - Port 1: divider operand pre-normalisation.
- Two-stage pipeline: round-robin arbitration into stage A (operand register), LZC plus post-processing into stage B (result register).
- Results are returned to the owning requester over per-port valid/ready.
- Sits beside the EX-stage ALU and the iterative divider; the LZC instance is internal.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- CNTW, 6, width of count result, so 32 is representable.

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; kills port-0 traffic only
- req0_valid_i  in  1  ALU request valid
- req0_ready_o  out  1  ALU request accepted when valid&ready
- req0_op_i  in  2  00 CLZ, 01 CTZ, 10 NORM, 11 reserved (treated as CLZ)
- req0_data_i  in  32  ALU operand
- req1_valid_i / req1_ready_o / req1_op_i / req1_data_i  same widths and meanings, divider port
- resp0_valid_o  out  1  ALU result valid
- resp0_ready_i  in  1  ALU accepts result
- resp1_valid_o / resp1_ready_i  same, divider port
- resp_cnt_o  out  6  count result, shared bus, meaningful for the port whose resp valid is high
- resp_data_o  out  32  NORM result (operand << count); 0 for CLZ/CTZ

Behaviour:
- Reset (reset=1 at clock edge):
  - Stage A and stage B valid cleared.
  - resp0_valid_o = resp1_valid_o = 0; resp_cnt_o = 0; resp_data_o = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - Reset overrides all other inputs the same cycle; in-flight operations are discarded and no response is emitted.
- Arbitration (combinational):
  - Only one valid: that port is granted.
  - Both valid: port != last_grant is granted.
  - last_grant updates only on an accepted transfer.
  - reqN_ready_o = grantN & a_can_load.
  - req0_ready_o is forced 0 while flush_i=1.
  - Ready never depends on resp readiness of the other port except through a_can_load.
- Stage A:
  - Holds {valid, owner, op, data}.
  - b_can_load = ~b_valid | (b_owner resp ready).
  - a_can_load = ~a_valid | b_can_load.
  - Loads on accepted request. Otherwise clears when it advances into B, or holds.
- Stage B compute (from stage A register):
  - CLZ: cnt = empty ? 32 : lzc(data).
  - CTZ: cnt = empty ? 32 : lzc(bitreverse(data)).
  - NORM: cnt as CLZ; data_out = data << lzc(data); zero operand gives data_out 0, cnt 32.
  - CLZ/CTZ: data_out = 0.
  - Registered into B when a_valid & b_can_load.
  - respN_valid_o = b_valid & (b_owner==N).
  - resp_cnt_o and resp_data_o are held stable while valid & ~ready.
- Latency and throughput:
  - Request accepted in cycle N → response valid in cycle N+2.
  - Sustained throughput is 1 per cycle when the response side is ready.
- Backpressure:
  - B stalled → A stalls → both req ready drop once A is full.
  - A stalled response on one port blocks the other port (single shared pipe, in-order).
- Flush (flush_i=1):
  - Stage A and stage B entries with owner 0 are invalidated at the edge.
  - No port-0 request is accepted that cycle.
  - Port-1 entries are unaffected and continue.
  - Flush of a stalled port-0 B entry frees B the next cycle.
- Simultaneous resp handshake and new load into B: the B register takes the new entry, with no bubble.
- Reserved op 11 behaves exactly as CLZ.

Test Plan:
- Reset then single port-0 CLZ of 0x0001_0000 with resp0_ready=1 → resp0_valid two cycles after accept, cnt=15, data=0.
- Port-1 NORM of 0x0000_00F0 → cnt=24, data=0xF000_0000.
- Port-1 NORM of 0 → cnt=32, data=0.
- Port-0 CTZ of 0x8000_0000 → cnt=31.
- Port-0 CTZ of 0 → cnt=32.
- Both ports valid every cycle, all responses ready → grants alternate 0,1,0,1 starting with port 0; one response per cycle; results in accept order.
- Port-0 request in B, resp0_ready=0 for 3 cycles while port 1 streams → both req ready deasserted once A full; resp fields stable; on resp0_ready=1 the pipeline drains with no loss or duplication.
- Port-0 op in A and another in B while stalled, flush_i pulsed, port-1 op arriving → port-0 entries never respond; port-1 result returned normally; req0_ready_o=0 during flush cycle.
- reset asserted mid-stream with both stages full → next cycle all resp valids 0 and port 0 wins the next tie.
